// File: rtl/alu_pkg.sv
// Shared types and constants for the ALU arbiter slice.
// ALU op codes, widths and arbiter FSM encoding.
package alu_pkg;

  localparam int NUM_REQ = 2;
  localparam int DATA_W  = 4;
  localparam int SEL_W   = 4;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ISSUE   = 2'd1,
    CAPTURE = 2'd2,
    RESP    = 2'd3
  } state_t;

  localparam logic [SEL_W-1:0] OP_ADD  = 4'd0;
  localparam logic [SEL_W-1:0] OP_SUB  = 4'd1;
  localparam logic [SEL_W-1:0] OP_MUL  = 4'd2;
  localparam logic [SEL_W-1:0] OP_DIV  = 4'd3;
  localparam logic [SEL_W-1:0] OP_MOD  = 4'd4;
  localparam logic [SEL_W-1:0] OP_SHL  = 4'd5;
  localparam logic [SEL_W-1:0] OP_SHR  = 4'd6;
  localparam logic [SEL_W-1:0] OP_NOT  = 4'd7;
  localparam logic [SEL_W-1:0] OP_AND  = 4'd8;
  localparam logic [SEL_W-1:0] OP_OR   = 4'd9;
  localparam logic [SEL_W-1:0] OP_XOR  = 4'd10;
  localparam logic [SEL_W-1:0] OP_NAND = 4'd11;
  localparam logic [SEL_W-1:0] OP_NOR  = 4'd12;
  localparam logic [SEL_W-1:0] OP_XNOR = 4'd13;
  localparam logic [SEL_W-1:0] OP_LT   = 4'd14;
  localparam logic [SEL_W-1:0] OP_EQ   = 4'd15;

  function automatic logic is_divzero(
    input logic [SEL_W-1:0]  s,
    input logic [DATA_W-1:0] b
  );
    return (s == OP_DIV) && (b == '0);
  endfunction

endpackage

// File: rtl/alu_arbiter_rr.sv
// rr_arbiter2: combinational 2-way round-robin grant.
// The requester at ptr wins; otherwise the other one if valid.
module rr_arbiter2
  import alu_pkg::*;
(
  input  logic [NUM_REQ-1:0] valid,
  input  logic               ptr,
  output logic [NUM_REQ-1:0] grant
);

  always_comb begin
    grant = '0;
    if (valid[ptr])
      grant[ptr] = 1'b1;
    else if (valid[!ptr])
      grant[!ptr] = 1'b1;
  end

endmodule

// File: rtl/alu_arbiter.sv
// Round-robin sharing of one combinational ALU by two requesters.
// Optional divide-by-zero short cut: define ALU_ARB_DIVZERO_EN.
module alu_arbiter
  import alu_pkg::*;
(
  input  logic                      clock_100Mhz,
  input  logic                      reset,
  input  logic [NUM_REQ-1:0]        req_valid,
  output logic [NUM_REQ-1:0]        req_ready,
  input  logic [NUM_REQ*DATA_W-1:0] req_a,
  input  logic [NUM_REQ*DATA_W-1:0] req_b,
  input  logic [NUM_REQ*SEL_W-1:0]  req_s,
  output logic [DATA_W-1:0]         alu_a,
  output logic [DATA_W-1:0]         alu_b,
  output logic [SEL_W-1:0]          alu_s,
  input  logic [DATA_W-1:0]         alu_result,
  output logic [NUM_REQ-1:0]        rsp_valid,
  input  logic [NUM_REQ-1:0]        rsp_ready,
  output logic [DATA_W-1:0]         rsp_data,
  output logic                      rsp_err,
  output logic                      busy
);

  state_t             state;
  logic               ptr;
  logic               id;
  logic [NUM_REQ-1:0] grant;
  logic               accept;
  logic               gid;
  logic [DATA_W-1:0]  sel_a;
  logic [DATA_W-1:0]  sel_b;
  logic [SEL_W-1:0]   sel_s;

  rr_arbiter2 u_rr (
    .valid (req_valid),
    .ptr   (ptr),
    .grant (grant)
  );

  assign req_ready = (state == IDLE && !reset) ? grant : '0;
  assign accept    = |(req_valid & req_ready);
  assign gid       = grant[1];

  assign sel_a = gid ? req_a[2*DATA_W-1:DATA_W] : req_a[DATA_W-1:0];
  assign sel_b = gid ? req_b[2*DATA_W-1:DATA_W] : req_b[DATA_W-1:0];
  assign sel_s = gid ? req_s[2*SEL_W-1:SEL_W]   : req_s[SEL_W-1:0];

  assign busy      = (state != IDLE);
  assign rsp_valid = (state == RESP) ? (id ? 2'b10 : 2'b01) : 2'b00;

`ifdef ALU_ARB_DIVZERO_EN
  logic err_q;
  assign rsp_err = err_q;
`else
  assign rsp_err = 1'b0;
`endif

  always_ff @(posedge clock_100Mhz) begin
    if (reset) begin
      state    <= IDLE;
      ptr      <= 1'b0;
      id       <= 1'b0;
      alu_a    <= '0;
      alu_b    <= '0;
      alu_s    <= '0;
      rsp_data <= '0;
`ifdef ALU_ARB_DIVZERO_EN
      err_q    <= 1'b0;
`endif
    end else begin
      unique case (state)
        IDLE: begin
          if (accept) begin
            id  <= gid;
            ptr <= !gid;
`ifdef ALU_ARB_DIVZERO_EN
            // Divide by zero never reaches the ALU.
            if (is_divzero(sel_s, sel_b)) begin
              rsp_data <= '1;
              err_q    <= 1'b1;
              state    <= RESP;
            end else begin
              alu_a <= sel_a;
              alu_b <= sel_b;
              alu_s <= sel_s;
              state <= ISSUE;
            end
`else
            alu_a <= sel_a;
            alu_b <= sel_b;
            alu_s <= sel_s;
            state <= ISSUE;
`endif
          end
        end
        ISSUE: state <= CAPTURE;
        CAPTURE: begin
          rsp_data <= alu_result;
          state    <= RESP;
        end
        RESP: begin
          if (rsp_ready[id]) begin
`ifdef ALU_ARB_DIVZERO_EN
            err_q <= 1'b0;
`endif
            state <= IDLE;
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_alu_arbiter.sv
// Scoreboard bench for alu_arbiter with a behavioural 4-bit ALU.
// Expectations follow ALU_ARB_DIVZERO_EN when it is defined.
module tb_alu_arbiter;
  import alu_pkg::*;

  logic       clock_100Mhz;
  logic       reset;
  logic [1:0] req_valid;
  logic [1:0] req_ready;
  logic [7:0] req_a;
  logic [7:0] req_b;
  logic [7:0] req_s;
  logic [3:0] alu_a;
  logic [3:0] alu_b;
  logic [3:0] alu_s;
  logic [3:0] alu_result;
  logic [1:0] rsp_valid;
  logic [1:0] rsp_ready;
  logic [3:0] rsp_data;
  logic       rsp_err;
  logic       busy;

  alu_arbiter dut (
    .clock_100Mhz (clock_100Mhz),
    .reset        (reset),
    .req_valid    (req_valid),
    .req_ready    (req_ready),
    .req_a        (req_a),
    .req_b        (req_b),
    .req_s        (req_s),
    .alu_a        (alu_a),
    .alu_b        (alu_b),
    .alu_s        (alu_s),
    .alu_result   (alu_result),
    .rsp_valid    (rsp_valid),
    .rsp_ready    (rsp_ready),
    .rsp_data     (rsp_data),
    .rsp_err      (rsp_err),
    .busy         (busy)
  );

  initial clock_100Mhz = 1'b0;
  always #5 clock_100Mhz = ~clock_100Mhz;

  function automatic logic [3:0] alu_fn(
    input logic [3:0] a,
    input logic [3:0] b,
    input logic [3:0] s
  );
    logic [3:0] r;
    case (s)
      OP_ADD:  r = a + b;
      OP_SUB:  r = a - b;
      OP_MUL:  r = a * b;
      OP_DIV:  r = (b == 4'd0) ? 4'd0 : a / b;
      OP_MOD:  r = (b == 4'd0) ? 4'd0 : a % b;
      OP_SHL:  r = a << b[1:0];
      OP_SHR:  r = a >> b[1:0];
      OP_NOT:  r = ~a;
      OP_AND:  r = a & b;
      OP_OR:   r = a | b;
      OP_XOR:  r = a ^ b;
      OP_NAND: r = ~(a & b);
      OP_NOR:  r = ~(a | b);
      OP_XNOR: r = ~(a ^ b);
      OP_LT:   r = {3'b000, a < b};
      default: r = {3'b000, a == b};
    endcase
    return r;
  endfunction

  always_comb alu_result = alu_fn(alu_a, alu_b, alu_s);

  typedef struct {
    logic [1:0] vld;
    logic [3:0] data;
    logic       err;
  } exp_t;

  exp_t sb[$];
  int   grant_log[$];
  int   n_chk = 0;
  int   n_pass = 0;
  int   acc_cnt = 0;
  int   rsp_cnt = 0;

  task automatic chk(
    input string       tag,
    input logic [31:0] got,
    input logic [31:0] exp
  );
    n_chk++;
    if (got === exp)
      n_pass++;
    else
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
  endtask

  task automatic tmo(input string tag);
    n_chk++;
    $display("FAIL %s timeout", tag);
  endtask

  // Monitor: push on accept, pop and compare on response handshake.
  always @(negedge clock_100Mhz) begin
    if (reset) begin
      sb.delete();
    end else begin
      chk("ready_onehot", ($countones(req_ready) <= 1), 1);
      chk("rspv_onehot", ($countones(rsp_valid) <= 1), 1);
      for (int i = 0; i < 2; i++) begin
        if (req_valid[i] && req_ready[i]) begin
          logic [3:0] a, b, s;
          exp_t e;
          a = req_a[i*4 +: 4];
          b = req_b[i*4 +: 4];
          s = req_s[i*4 +: 4];
          e.vld  = (i == 1) ? 2'b10 : 2'b01;
          e.data = alu_fn(a, b, s);
          e.err  = 1'b0;
`ifdef ALU_ARB_DIVZERO_EN
          if (s == OP_DIV && b == 4'd0) begin
            e.data = 4'hF;
            e.err  = 1'b1;
          end
`endif
          sb.push_back(e);
          grant_log.push_back(i);
          acc_cnt++;
        end
      end
      if ((rsp_valid & rsp_ready) != 2'b00) begin
        rsp_cnt++;
        if (sb.size() == 0) begin
          n_chk++;
          $display("FAIL sb_underflow rsp_valid=%b", rsp_valid);
        end else begin
          exp_t e;
          e = sb.pop_front();
          chk("sb_vld", rsp_valid, e.vld);
          chk("sb_data", rsp_data, e.data);
          chk("sb_err", rsp_err, e.err);
        end
      end
    end
  end

  task automatic tick();
    @(posedge clock_100Mhz);
    #1;
  endtask

  task automatic drive(
    input int         i,
    input logic [3:0] a,
    input logic [3:0] b,
    input logic [3:0] s
  );
    req_a[i*4 +: 4] = a;
    req_b[i*4 +: 4] = b;
    req_s[i*4 +: 4] = s;
    req_valid[i]    = 1'b1;
  endtask

  // Returns just after the edge at which requester i is accepted.
  task automatic wait_accept(input int i);
    bit done;
    done = 0;
    for (int k = 0; k < 60 && !done; k++) begin
      @(negedge clock_100Mhz);
      if (req_valid[i] && req_ready[i]) begin
        @(posedge clock_100Mhz);
        #1;
        done = 1;
      end
    end
    if (!done) tmo("accept");
  endtask

  task automatic wait_drain();
    bit done;
    done = 0;
    for (int k = 0; k < 100 && !done; k++) begin
      if (sb.size() == 0 && !busy) done = 1;
      else tick();
    end
    if (!done) tmo("drain");
  endtask

  initial begin
    #300000;
    $display("FAIL global timeout");
    $fatal(1, "global timeout");
  end

  initial begin
    int start;
    bit seen;
    reset     = 1'b1;
    req_valid = 2'b11;
    req_a     = '0;
    req_b     = '0;
    req_s     = '0;
    rsp_ready = 2'b00;
    tick();
    tick();
    chk("rst_ready", req_ready, 2'b00);
    chk("rst_rspv", rsp_valid, 2'b00);
    chk("rst_busy", busy, 0);
    chk("rst_alu", {alu_a, alu_b, alu_s}, 0);
    chk("rst_data", rsp_data, 0);
    chk("rst_err", rsp_err, 0);
    req_valid = 2'b00;
    reset     = 1'b0;
    tick();

    // Single op: 3 + 4
    rsp_ready = 2'b11;
    drive(0, 4'd3, 4'd4, OP_ADD);
    wait_accept(0);
    req_valid = 2'b00;
    chk("t1_alu_a", alu_a, 3);
    chk("t1_alu_b", alu_b, 4);
    chk("t1_alu_s", alu_s, 0);
    chk("t1_busy", busy, 1);
    chk("t1_rspv_n1", rsp_valid, 2'b00);
    tick();
    chk("t1_rspv_n2", rsp_valid, 2'b00);
    tick();
    chk("t1_rspv_n3", rsp_valid, 2'b01);
    chk("t1_data", rsp_data, 7);
    tick();
    chk("t1_idle", busy, 0);
    chk("t1_alu_hold", alu_a, 3);

    // Contention from a fresh pointer
    reset = 1'b1;
    tick();
    reset = 1'b0;
    grant_log.delete();
    drive(0, 4'd9, 4'd2, OP_SUB);
    drive(1, 4'd12, 4'd10, OP_AND);
    wait_accept(0);
    req_valid[0] = 1'b0;
    wait_accept(1);
    req_valid[1] = 1'b0;
    wait_drain();
    chk("t2_n", grant_log.size(), 2);
    chk("t2_g0", grant_log[0], 0);
    chk("t2_g1", grant_log[1], 1);

    // Fairness over six back-to-back ops
    grant_log.delete();
    drive(0, 4'd1, 4'd1, OP_ADD);
    drive(1, 4'd7, 4'd3, OP_MUL);
    start = acc_cnt;
    for (int k = 0; k < 200; k++) begin
      tick();
      if (acc_cnt - start >= 6) break;
    end
    req_valid = 2'b00;
    wait_drain();
    chk("t3_n", grant_log.size(), 6);
    for (int k = 0; k < 6; k++)
      chk("t3_order", grant_log[k], k % 2);

    // Backpressure on requester 1
    rsp_ready = 2'b00;
    drive(1, 4'd6, 4'd5, OP_OR);
    wait_accept(1);
    req_valid[1] = 1'b0;
    drive(0, 4'd2, 4'd2, OP_ADD);
    seen = 0;
    for (int k = 0; k < 20 && !seen; k++) begin
      if (rsp_valid != 2'b00) seen = 1;
      else tick();
    end
    if (!seen) tmo("t4_rsp");
    for (int k = 0; k < 5; k++) begin
      tick();
      chk("t4_rspv", rsp_valid, 2'b10);
      chk("t4_data", rsp_data, 7);
      chk("t4_ready", req_ready, 2'b00);
    end
    start = rsp_cnt;
    rsp_ready = 2'b11;
    wait_accept(0);
    req_valid = 2'b00;
    wait_drain();
    chk("t4_rsps", rsp_cnt - start, 2);

    // Reset while in CAPTURE
    drive(0, 4'd6, 4'd9, OP_XOR);
    wait_accept(0);
    req_valid = 2'b00;
    tick();
    start = rsp_cnt;
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk("t5_rspv", rsp_valid, 2'b00);
    chk("t5_alu", {alu_a, alu_b, alu_s}, 0);
    chk("t5_busy", busy, 0);
    chk("t5_data", rsp_data, 0);
    for (int k = 0; k < 5; k++) tick();
    chk("t5_norsp", rsp_cnt - start, 0);

    // Divide by zero
    drive(0, 4'd5, 4'd0, OP_DIV);
    wait_accept(0);
    req_valid = 2'b00;
`ifdef ALU_ARB_DIVZERO_EN
    chk("t6_rspv_n1", rsp_valid, 2'b01);
    chk("t6_data", rsp_data, 4'hF);
    chk("t6_err", rsp_err, 1);
    chk("t6_alu_s", alu_s, 0);
`else
    chk("t6_rspv_n1", rsp_valid, 2'b00);
    chk("t6_alu_s", alu_s, OP_DIV);
    tick();
    tick();
    chk("t6_rspv_n3", rsp_valid, 2'b01);
    chk("t6_err", rsp_err, 0);
`endif
    wait_drain();

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
